// File: rtl/add_sequencer_pkg.sv
// Shared definitions for the byte-serial adder sequencer: slice geometry,
// FSM state encoding and the signed-overflow helper.
package alu_seq_pkg;

    localparam int SLICE_W    = 8;
    localparam int NUM_SLICES = 4;
    localparam int DATA_W     = SLICE_W * NUM_SLICES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic calc_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/add_sequencer_if.sv
// Request/response bundle of the adder sequencer. The op signal exists only
// when ADD_SEQUENCER_SUB_EN is defined.
interface add_sequencer_if;
    import alu_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              c_in;
`ifdef ADD_SEQUENCER_SUB_EN
    logic              op;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] sum;
    logic              c_out;
    logic              ovf;

    modport slave (
        input  in_valid, a, b, c_in,
`ifdef ADD_SEQUENCER_SUB_EN
        input  op,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );

    modport master (
        output in_valid, a, b, c_in,
`ifdef ADD_SEQUENCER_SUB_EN
        output op,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

endinterface

// File: rtl/add_sequencer_cla_slice8.sv
// 8-bit carry-lookahead adder slice. Every internal carry is formed directly
// from the generate/propagate terms and the slice carry-in, so there is no
// bit-to-bit ripple inside the slice.
module cla_slice8
    import alu_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               c_in,
    output logic [SLICE_W-1:0] s,
    output logic               c_out
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W:0]   c;

    // Sum-of-products lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c_in.
    always_comb begin
        logic acc;
        logic prod;
        acc  = 1'b0;
        prod = 1'b0;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = c_in;
        for (int i = 0; i < SLICE_W; i++) begin
            acc = 1'b0;
            for (int j = 0; j <= i; j++) begin
                prod = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    prod = prod & p[k];
                end
                acc = acc | prod;
            end
            prod = c_in;
            for (int k = 0; k <= i; k++) begin
                prod = prod & p[k];
            end
            c[i+1] = acc | prod;
        end
        s     = p ^ c[SLICE_W-1:0];
        c_out = c[SLICE_W];
    end

endmodule

// File: rtl/add_sequencer.sv
// Byte-serial 32-bit adder: one 8-bit lookahead slice reused over four
// cycles, least significant byte first. Optional subtract mode is enabled
// by defining ADD_SEQUENCER_SUB_EN (adds the op input; op=1 computes a-b).
//
//   state | meaning
//   IDLE  | ready for a request, in_ready high
//   RUN   | one byte per edge, slice_idx selects the byte
//   DONE  | result held with out_valid high until out_ready
module add_sequencer
    import alu_seq_pkg::*;
(
    input  logic           clock,
    input  logic           reset_n,
    add_sequencer_if.slave bus
);

    seq_state_t        state;
    logic [1:0]        slice_idx;
    logic              carry_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] sum_r;
    logic              c_out_r;
    logic              ovf_r;
`ifdef ADD_SEQUENCER_SUB_EN
    logic              op_r;
`endif

    logic [DATA_W-1:0]  b_eff;
    logic               carry_start;
    logic [SLICE_W-1:0] x_byte;
    logic [SLICE_W-1:0] y_byte;
    logic [SLICE_W-1:0] s_byte;
    logic               slice_cout;
    logic               last_slice;

    // Effective second operand and the carry seeded into byte 0.
    always_comb begin
`ifdef ADD_SEQUENCER_SUB_EN
        b_eff       = op_r ? ~b_r : b_r;
        carry_start = bus.op ? 1'b1 : bus.c_in;
`else
        b_eff       = b_r;
        carry_start = bus.c_in;
`endif
    end

    // Operand byte selection for the shared slice.
    always_comb begin
        x_byte     = a_r[{slice_idx, 3'b000} +: SLICE_W];
        y_byte     = b_eff[{slice_idx, 3'b000} +: SLICE_W];
        last_slice = (slice_idx == 2'(NUM_SLICES - 1));
    end

    cla_slice8 u_slice (
        .x     (x_byte),
        .y     (y_byte),
        .c_in  (carry_r),
        .s     (s_byte),
        .c_out (slice_cout)
    );

    // Sequencer FSM: accept, step through the bytes, hold the result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            slice_idx <= 2'd0;
            carry_r   <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            sum_r     <= '0;
            c_out_r   <= 1'b0;
            ovf_r     <= 1'b0;
`ifdef ADD_SEQUENCER_SUB_EN
            op_r      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r       <= bus.a;
                        b_r       <= bus.b;
                        carry_r   <= carry_start;
`ifdef ADD_SEQUENCER_SUB_EN
                        op_r      <= bus.op;
`endif
                        slice_idx <= 2'd0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum_r[{slice_idx, 3'b000} +: SLICE_W] <= s_byte;
                    carry_r <= slice_cout;
                    if (last_slice) begin
                        c_out_r   <= slice_cout;
                        ovf_r     <= calc_ovf(a_r[DATA_W-1], b_eff[DATA_W-1], s_byte[SLICE_W-1]);
                        slice_idx <= 2'd0;
                        state     <= DONE;
                    end else begin
                        slice_idx <= slice_idx + 2'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_r;
    assign bus.c_out     = c_out_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_add_sequencer.sv
// Self-checking bench for add_sequencer: table of vectors plus random
// operands through a scoreboard, with hand sequences for back-pressure and
// reset abort. Honors ADD_SEQUENCER_SUB_EN when defined.
module tb_add_sequencer;
    import alu_seq_pkg::*;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        op;
        exp_t        exp;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    always #5 clock = ~clock;

    add_sequencer_if bus();

    add_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic op);
        exp_t        r;
        logic [31:0] be;
        logic        ci;
        logic [32:0] full;
        be     = op ? ~b : b;
        ci     = op ? 1'b1 : cin;
        full   = {1'b0, a} + {1'b0, be} + {32'd0, ci};
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = (a[31] == be[31]) && (full[31] != a[31]);
        return r;
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                input logic op, input logic [31:0] s, input logic co,
                                input logic ov);
        vec_t v;
        v.a        = a;
        v.b        = b;
        v.cin      = cin;
        v.op       = op;
        v.exp.sum  = s;
        v.exp.cout = co;
        v.exp.ovf  = ov;
        return v;
    endfunction

    task automatic set_inputs(input logic [31:0] a, input logic [31:0] b, input logic cin,
                              input logic op);
        bus.a    = a;
        bus.b    = b;
        bus.c_in = cin;
`ifdef ADD_SEQUENCER_SUB_EN
        bus.op   = op;
`else
        if (op) $display("note: op ignored, subtract mode not built");
`endif
    endtask

    // Issue one operation (called at a negedge in IDLE); hold_cycles keeps
    // out_ready low that many cycles once out_valid appears.
    task automatic run_op(input vec_t v, input int hold_cycles);
        int   lat;
        exp_t e;
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        set_inputs(v.a, v.b, v.cin, v.op);
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold_cycles == 0);
        @(posedge clock);
        sb_q.push_back(v.exp);
        @(negedge clock);
        // Garbage on the request side while busy must not disturb the result.
        set_inputs($urandom, $urandom, 1'($urandom), 1'b0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            check("in_ready_busy", 64'(bus.in_ready), 64'd0);
            @(negedge clock);
            lat++;
        end
        check("latency", 64'(lat), 64'd4);
        bus.in_valid = 1'b0;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
            return;
        end
        e = sb_q[0];
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clock);
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_sum", 64'(bus.sum), 64'(e.sum));
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        e = sb_q.pop_front();
        check("sum", 64'(bus.sum), 64'(e.sum));
        check("c_out", 64'(bus.c_out), 64'(e.cout));
        check("ovf", 64'(bus.ovf), 64'(e.ovf));
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("post_valid", 64'(bus.out_valid), 64'd0);
        check("post_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_valid;
        vec_t v;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_inputs(32'd0, 32'd0, 1'b0, 1'b0);

        vecs.push_back(mk(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0));
        vecs.push_back(mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1));
        vecs.push_back(mk(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1));
        vecs.push_back(mk(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0));
        vecs.push_back(mk(32'h00FF_FF00, 32'h0001_0100, 1'b0, 1'b0, 32'h0101_0000, 1'b0, 1'b0));
`ifdef ADD_SEQUENCER_SUB_EN
        vecs.push_back(mk(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0));
        vecs.push_back(mk(32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0));
        vecs.push_back(mk(32'h8000_0000, 32'd1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1));
`endif

        // Reset state.
        @(negedge clock);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sum", 64'(bus.sum), 64'd0);
        check("rst_c_out", 64'(bus.c_out), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        foreach (vecs[i]) run_op(vecs[i], 0);

        for (int i = 0; i < 8; i++) begin
            v.a   = $urandom;
            v.b   = $urandom;
            v.cin = 1'($urandom);
`ifdef ADD_SEQUENCER_SUB_EN
            v.op  = 1'($urandom);
`else
            v.op  = 1'b0;
`endif
            v.exp = model(v.a, v.b, v.cin, v.op);
            run_op(v, 0);
        end

        // Back-pressure: result held for 10 cycles with out_ready low.
        run_op(mk(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0, 32'hDFAE_BFF0, 1'b0, 1'b0), 10);

        // Reset abort during RUN slice 2.
        set_inputs(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_sum", 64'(bus.sum), 64'd0);
        check("abort_c_out", 64'(bus.c_out), 64'd0);
        check("abort_ovf", 64'(bus.ovf), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        n_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (bus.out_valid) n_valid++;
        end
        check("abort_no_valid", 64'(n_valid), 64'd0);
        bus.out_ready = 1'b0;

        // Normal operation after the abort.
        run_op(mk(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0), 0);

        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/add_sequencer.md
ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, request carries valid operands.
REQ-004 SHALL have port in_ready, output, 1, block can accept a request.
REQ-005 SHALL have ports a and b, input, 32 each, operands.
REQ-006 SHALL have port c_in, input, 1, carry into bit 0 (add mode).
REQ-007 SHALL have port op, input, 1, 0=add, 1=subtract; present only when SUB_EN is defined.
REQ-008 SHALL have port out_valid, output, 1, result is valid.
REQ-009 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-010 SHALL have ports sum (output, 32, result), c_out (output, 1, carry out of bit 31), ovf (output, 1, signed overflow).

Function
REQ-011 SHALL compute the 32-bit result with one 8-bit carry-lookahead slice reused over 4 cycles, least significant byte first.
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-013 SHALL assert in_ready only in IDLE; accept on the edge where in_valid and in_ready are both 1, registering a, b, c_in (and op) and moving to RUN with slice index 0.
REQ-014 SHALL in RUN, per edge, process byte k (k=0..3): write slice sum to sum[8k+7:8k], register slice carry-out as carry into byte k+1; index wraps to DONE after k=3.
REQ-015 SHALL assert out_valid exactly 4 edges after the accepting edge; sum, c_out, ovf stable while out_valid is 1.
REQ-016 SHALL hold DONE until out_valid and out_ready are both 1, then return to IDLE on that edge; earliest next acceptance is the following edge (min 6 cycles per operation).
REQ-017 SHALL ignore changes on a, b, c_in, op and in_valid while in RUN or DONE.
REQ-018 SHALL ignore out_ready in IDLE and RUN.
REQ-019 SHALL set c_out to carry-out of byte 3 and ovf to 1 iff a[31] equals effective b[31] and sum[31] differs from a[31].
REQ-020 SHALL treat all arithmetic as unsigned 32-bit modulo 2^32; c_out is the 33rd bit.

Reset
REQ-021 SHALL on reset_n low, immediately force FSM to IDLE, slice index 0, carry register 0, sum 0, c_out 0, ovf 0, out_valid 0; in_ready 1 after reset deassertion.
REQ-022 SHALL discard any in-flight operation on reset mid-RUN or mid-DONE; no out_valid is produced for it.

Configuration
REQ-023 SHALL with macro ADD_SEQUENCER_SUB_EN defined, provide op; op=1 uses inverted registered b and forces carry into byte 0 to 1 (c_in ignored).
REQ-024 SHALL with ADD_SEQUENCER_SUB_EN undefined, omit op and always add a+b+c_in.

Structure
REQ-025 SHALL place state enum (IDLE, RUN, DONE), SLICE_W=8 and NUM_SLICES=4 in shared package alu_seq_pkg.
REQ-026 SHALL instantiate one combinational sub-module cla_slice8 (x[7:0], y[7:0], c_in -> s[7:0], c_out) built from per-bit propagate/generate lookahead.

Verification
REQ-027 SHALL cover: a=0x0000_00FF, b=0x0000_0001, c_in=0 -> 4 edges later sum=0x0000_0100, c_out=0, ovf=0.
REQ-028 SHALL cover: a=0xFFFF_FFFF, b=0x0000_0000, c_in=1 -> sum=0x0000_0000, c_out=1, ovf=0 (carry ripples through all 4 slices).
REQ-029 SHALL cover: a=0x7FFF_FFFF, b=0x0000_0001, c_in=0 -> sum=0x8000_0000, ovf=1, c_out=0.
REQ-030 SHALL cover: with ADD_SEQUENCER_SUB_EN, op=1, a=5, b=7 -> sum=0xFFFF_FFFE, c_out=0, ovf=0.
REQ-031 SHALL cover: out_ready held 0 for 10 cycles in DONE -> out_valid and sum held, in_ready 0; then out_ready=1 -> IDLE next edge, in_ready 1.
REQ-032 SHALL cover: reset_n pulsed low during RUN slice 2 -> all outputs 0 immediately, in_ready 1 after release, no out_valid for aborted operation.
